// File: rtl/fp_pkg.sv
// Shared floating-point definitions for fp_adder and its downstream stages.
// Holds the exception-flag bit positions, the flag vector type and the
// canonical quiet-NaN encodings.
package fp_pkg;

  localparam int FLAGS_W = 5;

  // Exception flag bit positions inside fp_flags_t, fflags order {NV,DZ,OF,UF,NX}.
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef logic [FLAGS_W-1:0] fp_flags_t;

  // Canonical quiet NaNs produced by fp_adder for invalid operations.
  localparam logic [31:0] QNAN_S = 32'h7FC0_0000;
  localparam logic [15:0] QNAN_H = 16'h7E00;

  // True when the flag vector reports an invalid operation.
  function automatic logic flags_invalid(input fp_flags_t f);
    return f[FLAG_NV];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose : generic register-based synchronous FIFO with an occupancy count.
// Latency : 1 cycle write-to-read, head read combinationally from storage.
// Backpr. : writes ignored while full (even if a read happens), reads ignored while empty.
// Ports   : clk, rst_n (async active-low); wr_en/wr_data write side;
//           rd_en/rd_data read side (rd_data = head entry); full, empty, level.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 37
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  input  logic                       rd_en,
  output logic [DW-1:0]              rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_wr;
  logic          do_rd;

  // Full/empty come from the count; pointers alone are ambiguous when equal.
  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);

  // Write gating uses full only, so a full FIFO refuses a write even when
  // it is being read in the same cycle (keeps the write-side ready free of
  // any path from the read side).
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign rd_data = mem[rd_ptr];
  assign level   = count;

  // Storage is reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_result_collector.sv
// Purpose : buffers fp_adder results+flags in order and keeps sticky fflags.
// Latency : 1 cycle from accepted input to out_valid (no empty bypass).
// Backpr. : in_ready = not full (state only); full refuses pushes even on a same-cycle pop.
// Ports   : clk, rst_n (async active-low); in_result/in_flags/in_valid/in_ready
//           from fp_adder; out_result/out_flags/out_valid/out_ready to the consumer;
//           flags_clr clears flags_sticky; level is current occupancy 0..DEPTH.
module fp_result_collector
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_result,
  input  logic [FLAGS_W-1:0]         in_flags,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic [FLAGS_W-1:0]         out_flags,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flags_clr,
  output logic [FLAGS_W-1:0]         flags_sticky,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int EW = WIDTH + FLAGS_W;

  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   head_entry;
  fp_flags_t       sticky_q;
  fp_flags_t       sticky_d;

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;

  // Result stored verbatim; half-precision results simply live in [15:0].
  assign wr_entry   = {in_result, in_flags};
  assign out_result = head_entry[EW-1:FLAGS_W];
  assign out_flags  = head_entry[FLAGS_W-1:0];

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (out_ready),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // A clear coinciding with a capture keeps the new flags, so no exception
  // raised on the clear edge is ever lost.
  always_comb begin
    sticky_d = sticky_q;
    if (flags_clr && push) begin
      sticky_d = fp_flags_t'(in_flags);
    end else if (flags_clr) begin
      sticky_d = '0;
    end else if (push) begin
      sticky_d = sticky_q | fp_flags_t'(in_flags);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign flags_sticky = sticky_q;

endmodule

// File: tb/tb_fp_result_collector.sv
// Bench for fp_result_collector: scoreboard queue filled from driven pushes,
// checked against the head entry, plus occupancy and sticky-flag model.
module tb_fp_result_collector;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int LW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_result;
  logic [4:0]       in_flags;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_result;
  logic [4:0]       out_flags;
  logic             out_valid;
  logic             out_ready;
  logic             flags_clr;
  logic [4:0]       flags_sticky;
  logic [LW-1:0]    level;

  logic [WIDTH+4:0] exp_q[$];
  logic [4:0]       exp_sticky;
  logic [WIDTH+4:0] h;
  int               checks;
  int               errors;

  always #5 clk = ~clk;

  fp_result_collector #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .flags_clr    (flags_clr),
    .flags_sticky (flags_sticky),
    .level        (level)
  );

  // Advance the model by one edge using the currently driven inputs, then
  // step to 1 time unit after the rising edge.
  task automatic tick();
    bit push_ok;
    bit pop_ok;
    push_ok = in_valid && (exp_q.size() != DEPTH);
    pop_ok  = out_ready && (exp_q.size() != 0);
    if (flags_clr && push_ok)  exp_sticky = in_flags;
    else if (flags_clr)        exp_sticky = 5'b0;
    else if (push_ok)          exp_sticky = exp_sticky | in_flags;
    if (pop_ok)  void'(exp_q.pop_front());
    if (push_ok) exp_q.push_back({in_result, in_flags});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (out_result !== '0) begin errors++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
    checks++; if (out_flags !== 5'b0) begin errors++; $display("FAIL reset_out_flags: got %b expected 0", out_flags); end
    checks++; if (flags_sticky !== 5'b0) begin errors++; $display("FAIL reset_sticky: got %b expected 0", flags_sticky); end
  endtask

  task automatic test_passthrough();
    in_result = 32'h41B8_0000; in_flags = 5'b00000; in_valid = 1'b1; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_no_bypass: got %b expected 0", out_valid); end
    tick();
    in_valid = 1'b0;
    h = exp_q[0];
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pass_out_valid: got %b expected 1", out_valid); end
    checks++; if (out_result !== h[WIDTH+4:5]) begin errors++; $display("FAIL pass_result: got %h expected %h", out_result, h[WIDTH+4:5]); end
    tick();
    checks++; if (level !== LW'(exp_q.size())) begin errors++; $display("FAIL pass_level: got %0d expected %0d", level, exp_q.size()); end
    checks++; if (flags_sticky !== exp_sticky) begin errors++; $display("FAIL pass_sticky: got %b expected %b", flags_sticky, exp_sticky); end
  endtask

  task automatic test_backpressure();
    logic [31:0] vals [4];
    vals[0] = 32'h3FE0_0000; vals[1] = 32'h41BE_0000;
    vals[2] = 32'hBE00_0000; vals[3] = 32'h0000_0004;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_result = vals[i]; in_flags = 5'(i); in_valid = 1'b1;
      tick();
    end
    checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL bp_level_full: got %0d expected %0d", level, DEPTH); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
    in_result = 32'hDEAD_BEEF; in_flags = 5'b11111;
    tick();
    in_valid = 1'b0;
    checks++; if (level !== LW'(exp_q.size())) begin errors++; $display("FAIL bp_fifth_refused: got %0d expected %0d", level, exp_q.size()); end
    checks++; if (flags_sticky !== exp_sticky) begin errors++; $display("FAIL bp_sticky: got %b expected %b", flags_sticky, exp_sticky); end
    out_ready = 1'b1;
    for (int n = 0; n < DEPTH && exp_q.size() != 0; n++) begin
      h = exp_q[0];
      checks++; if (out_result !== h[WIDTH+4:5] || out_flags !== h[4:0]) begin errors++; $display("FAIL bp_drain_%0d: got %h/%b expected %h/%b", n, out_result, out_flags, h[WIDTH+4:5], h[4:0]); end
      tick();
      if (n == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", in_ready); end
      end
    end
    checks++; if (level !== '0) begin errors++; $display("FAIL bp_level_empty: got %0d expected 0", level); end
  endtask

  task automatic test_sticky();
    out_ready = 1'b0;
    in_result = 32'h7FC0_0000; in_flags = 5'b10000; in_valid = 1'b1;
    tick();
    in_result = 32'h0000_0004; in_flags = 5'b00011;
    tick();
    in_valid = 1'b0;
    checks++; if (flags_sticky !== exp_sticky || flags_sticky !== 5'b10011) begin errors++; $display("FAIL sticky_accum: got %b expected %b", flags_sticky, exp_sticky); end
    out_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      h = exp_q[0];
      checks++; if (out_flags !== h[4:0]) begin errors++; $display("FAIL sticky_entry_flags_%0d: got %b expected %b", n, out_flags, h[4:0]); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_clear_collision();
    flags_clr = 1'b1; in_valid = 1'b1; in_result = 32'h3F80_0000; in_flags = 5'b00001;
    tick();
    in_valid = 1'b0;
    checks++; if (flags_sticky !== exp_sticky) begin errors++; $display("FAIL clr_collision: got %b expected %b", flags_sticky, exp_sticky); end
    tick();
    flags_clr = 1'b0;
    checks++; if (flags_sticky !== exp_sticky) begin errors++; $display("FAIL clr_alone: got %b expected %b", flags_sticky, exp_sticky); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_result = 32'h1000_0000 + 32'(i); in_flags = 5'b00100; in_valid = 1'b1;
      tick();
    end
    in_result = 32'h5555_0055; in_flags = 5'b01000; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    tick();
    checks++; if (level !== LW'(exp_q.size())) begin errors++; $display("FAIL full_pop_refuse: got %0d expected %0d", level, exp_q.size()); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    h = exp_q[0];
    checks++; if (level !== LW'(exp_q.size())) begin errors++; $display("FAIL full_next_push: got %0d expected %0d", level, exp_q.size()); end
    checks++; if (out_result !== h[WIDTH+4:5]) begin errors++; $display("FAIL full_head: got %h expected %h", out_result, h[WIDTH+4:5]); end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_sticky = 5'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    checks++; if (level !== '0) begin errors++; $display("FAIL rstmid_level: got %0d expected 0", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    checks++; if (flags_sticky !== 5'b0) begin errors++; $display("FAIL rstmid_sticky: got %b expected 0", flags_sticky); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_result = 32'h4010_0000; in_flags = 5'b00000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    h = exp_q[0];
    checks++; if (out_valid !== 1'b1 || out_result !== h[WIDTH+4:5]) begin errors++; $display("FAIL rstmid_after: got %b/%h expected 1/%h", out_valid, out_result, h[WIDTH+4:5]); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 200; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flags_clr = ($urandom_range(0, 9) == 0);
      in_result = $urandom;
      in_flags  = 5'($urandom_range(0, 31));
      checks++; if (out_valid !== (exp_q.size() != 0) || level !== LW'(exp_q.size()) || in_ready !== (exp_q.size() != DEPTH)) begin
        errors++; $display("FAIL b2b_status_%0d: got v%b l%0d r%b expected size %0d", c, out_valid, level, in_ready, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        checks++; if (out_result !== h[WIDTH+4:5] || out_flags !== h[4:0]) begin errors++; $display("FAIL b2b_head_%0d: got %h/%b expected %h/%b", c, out_result, out_flags, h[WIDTH+4:5], h[4:0]); end
      end
      checks++; if (flags_sticky !== exp_sticky) begin errors++; $display("FAIL b2b_sticky_%0d: got %b expected %b", c, flags_sticky, exp_sticky); end
      tick();
    end
    in_valid = 1'b0; flags_clr = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 2*DEPTH && exp_q.size() != 0; n++) tick();
    checks++; if (level !== '0) begin errors++; $display("FAIL b2b_drained: got %0d expected 0", level); end
    out_ready = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_sticky = 5'b0;
    rst_n = 1'b0; in_result = '0; in_flags = '0; in_valid = 1'b0;
    out_ready = 1'b0; flags_clr = 1'b0;
    #1;
    test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_passthrough();
    test_backpressure();
    test_sticky();
    test_clear_collision();
    test_full_pop();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
